// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Purpose  : Shared frame constants, bit-index type and channel helper for
//             the audio serial master.
//  Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // A frame is 64 BCLK periods: 32 left-channel slots then 32 right-channel slots
    localparam int c_FRAME_BITS = 64;
    localparam int c_CHAN_BITS  = 32;
    localparam int c_BIT_CNT_W  = 6;

    typedef logic [c_BIT_CNT_W-1:0] bit_idx_t;

    // Left channel occupies the lower half of the frame
    function automatic logic is_left(input bit_idx_t idx);
        return (idx < bit_idx_t'(c_CHAN_BITS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_bclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : audio_bclk_gen
//  Purpose  : BCLK divider. Toggles bclk every BCLK_DIV system clocks and
//             flags the cycle in which each rising/falling toggle happens.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_bclk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic o_bclk,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [7:0] c_TC = 8'(BCLK_DIV - 1);

    logic [7:0] r_div;
    logic       r_bclk;
    logic       w_tc;

    assign w_tc = (r_div == c_TC);

    // Divider count and bclk toggle; bclk idles high so the first toggle falls
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_div  <= 8'd0;
            r_bclk <= 1'b1;
        end else if (w_tc) begin
            r_div  <= 8'd0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 8'd1;
        end
    end

    // Strobes are valid in the cycle whose edge performs the toggle
    assign o_bclk = r_bclk;
    assign o_fall = w_tc &  r_bclk;
    assign o_rise = w_tc & ~r_bclk;

endmodule
`default_nettype wire

// File: rtl/audio_serial_master.sv
`default_nettype none
// ============================================================================
//  Module   : audio_serial_master
//  Purpose  : Left-justified stereo serial link master. Generates bclk/lrclk,
//             serializes a buffered playback pair each frame and, when the
//             receive path is built, captures a stereo pair from sdata_in.
//  Options  : define AUDIO_MASTER_RX_EN to build the receive path; without it
//             rx_left/rx_right/rx_valid are tied to 0 and sdata_in is ignored.
//  Notes    : DATA_WIDTH must lie in 2..32.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_serial_master
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int BCLK_DIV   = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    output logic                  rx_valid,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata_out,
    input  logic                  sdata_in
);

    localparam bit_idx_t c_LAST_BIT = bit_idx_t'(c_FRAME_BITS - 1);
    // Last slot within a half-frame that carries sample data
    localparam logic [c_BIT_CNT_W-2:0] c_LAST_DATA = (c_BIT_CNT_W-1)'(DATA_WIDTH - 1);

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_wrap;
    logic                  w_accept;
    logic                  w_ready;
    logic                  w_data_slot;
    bit_idx_t              w_nb;
    logic [DATA_WIDTH-1:0] w_load_l;
    logic [DATA_WIDTH-1:0] w_load_r;

    bit_idx_t              r_bit;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic [DATA_WIDTH-1:0] r_sh_l;
    logic [DATA_WIDTH-1:0] r_sh_r;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_l;
    logic [DATA_WIDTH-1:0] r_hold_r;

    audio_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .o_bclk   (bclk),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    // Index the frame will move to on this falling toggle
    assign w_nb        = r_bit + 1'b1;
    assign w_wrap      = w_fall & (r_bit == c_LAST_BIT);
    assign w_data_slot = (w_nb[c_BIT_CNT_W-2:0] <= c_LAST_DATA);

    // Holding register is ready only outside reset, so tx_ready reads 0 in reset
    assign w_ready  = ~r_hold_full & ~reset;
    assign w_accept = tx_valid & w_ready;
    assign tx_ready = w_ready;

    // An empty holding register at the wrap yields a silent (all-zero) frame
    assign w_load_l = r_hold_full ? r_hold_l : '0;
    assign w_load_r = r_hold_full ? r_hold_r : '0;

    // Single-entry holding register; a wrap drains it and may refill it at once
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else begin
            if (w_accept) begin
                r_hold_l <= tx_left;
                r_hold_r <= tx_right;
            end
            if (w_wrap) begin
                r_hold_full <= w_accept;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end
        end
    end

    // Bit counter, lrclk and MSB-first serializer, all stepped on bclk falls
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_bit   <= c_LAST_BIT;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_sh_l  <= '0;
            r_sh_r  <= '0;
        end else if (w_fall) begin
            r_bit   <= w_nb;
            r_lrclk <= is_left(w_nb);
            if (w_wrap) begin
                // Left MSB goes straight out at slot 0; the rest stays queued
                r_sdata <= w_load_l[DATA_WIDTH-1];
                r_sh_l  <= w_load_l << 1;
                r_sh_r  <= w_load_r;
            end else if (w_data_slot && is_left(w_nb)) begin
                r_sdata <= r_sh_l[DATA_WIDTH-1];
                r_sh_l  <= r_sh_l << 1;
            end else if (w_data_slot) begin
                r_sdata <= r_sh_r[DATA_WIDTH-1];
                r_sh_r  <= r_sh_r << 1;
            end else begin
                r_sdata <= 1'b0;
            end
        end
    end

    assign lrclk     = r_lrclk;
    assign sdata_out = r_sdata;

`ifdef AUDIO_MASTER_RX_EN
    logic [DATA_WIDTH-1:0] r_rx_sh_l;
    logic [DATA_WIDTH-1:0] r_rx_sh_r;
    logic [DATA_WIDTH-1:0] r_rx_left;
    logic [DATA_WIDTH-1:0] r_rx_right;
    logic                  r_rx_valid;
    logic                  w_rx_slot;

    // On a rising toggle r_bit still names the slot being received
    assign w_rx_slot = (r_bit[c_BIT_CNT_W-2:0] <= c_LAST_DATA);

    // Capture MSB-first on bclk rises; publish both channels after the right LSB
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_rx_sh_l  <= '0;
            r_rx_sh_r  <= '0;
            r_rx_left  <= '0;
            r_rx_right <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rise && w_rx_slot) begin
                if (is_left(r_bit)) begin
                    r_rx_sh_l <= {r_rx_sh_l[DATA_WIDTH-2:0], sdata_in};
                end else begin
                    r_rx_sh_r <= {r_rx_sh_r[DATA_WIDTH-2:0], sdata_in};
                    if (r_bit[c_BIT_CNT_W-2:0] == c_LAST_DATA) begin
                        r_rx_left  <= r_rx_sh_l;
                        r_rx_right <= {r_rx_sh_r[DATA_WIDTH-2:0], sdata_in};
                        r_rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign rx_left  = r_rx_left;
    assign rx_right = r_rx_right;
    assign rx_valid = r_rx_valid;
`else
    // Receive path not built: serial input and rising strobe have no consumer
    logic w_unused_rx;
    assign w_unused_rx = sdata_in ^ w_rise;

    assign rx_left  = '0;
    assign rx_right = '0;
    assign rx_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_serial_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_serial_master
//  Purpose  : Frame-level directed bench for audio_serial_master with the
//             serial output looped back to the serial input.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_serial_master;

    localparam int DW  = 14;
    localparam int DIV = 2;

`ifdef AUDIO_MASTER_RX_EN
    localparam int c_RX = 1;
`else
    localparam int c_RX = 0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic [DW-1:0] tx_left  = '0;
    logic [DW-1:0] tx_right = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_left;
    logic [DW-1:0] rx_right;
    logic          rx_valid;
    logic          bclk;
    logic          lrclk;
    logic          sdata_out;
    logic          sdata_in;

    assign sdata_in = sdata_out;

    audio_serial_master #(
        .DATA_WIDTH (DW),
        .BCLK_DIV   (DIV)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .tx_left   (tx_left),
        .tx_right  (tx_right),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_left   (rx_left),
        .rx_right  (rx_right),
        .rx_valid  (rx_valid),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int            n_vec = 0;
    int            n_bad = 0;
    int            rxv_cnt = 0;
    logic [DW-1:0] rxl_seen = '0;
    logic [DW-1:0] rxr_seen = '0;

    // One frame: offer (ob = bit index, -1 none), optional late offer right
    // before the next wrap, expected serial stream / tx_ready per bit / rx pair
    typedef struct {
        int            ob;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          late;
        logic [DW-1:0] ll;
        logic [DW-1:0] lr;
        logic [63:0]   exp_bits;
        logic [63:0]   exp_rdy;
        logic [DW-1:0] fl;
        logic [DW-1:0] fr;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one system clock; retire a pending offer once it was accepted
    task automatic cyc();
        logic acc;
        acc = tx_valid & tx_ready;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        if (acc) tx_valid = 1'b0;
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
            rxl_seen = rx_left;
            rxr_seen = rx_right;
        end
    endtask

    // Runs one 64-bit frame; each bit is 4 clocks: fall, low, rise, high
    task automatic run_frame(input vec_t v, input int idx);
        logic [63:0] bits;
        logic [63:0] lrs;
        logic [63:0] rdys;
        int          bclk_err;
        bclk_err = 0;
        rxv_cnt  = 0;
        rxl_seen = '0;
        rxr_seen = '0;
        for (int b = 0; b < 64; b++) begin
            cyc();
            bits[63-b] = sdata_out;
            lrs[63-b]  = lrclk;
            rdys[63-b] = tx_ready;
            if (bclk !== 1'b0) bclk_err++;
            if (b == v.ob) begin
                tx_left  = v.l;
                tx_right = v.r;
                tx_valid = 1'b1;
            end
            cyc();
            if (bclk !== 1'b0) bclk_err++;
            cyc();
            if (bclk !== 1'b1) bclk_err++;
            cyc();
            if (bclk !== 1'b1) bclk_err++;
        end
        if (v.late) begin
            tx_left  = v.ll;
            tx_right = v.lr;
            tx_valid = 1'b1;
        end
        chk($sformatf("frame%0d sdata_out", idx), bits, v.exp_bits);
        chk($sformatf("frame%0d lrclk", idx), lrs, 64'hFFFF_FFFF_0000_0000);
        chk($sformatf("frame%0d tx_ready", idx), rdys, v.exp_rdy);
        chk($sformatf("frame%0d bclk errors", idx), 64'(bclk_err), 64'd0);
        chk($sformatf("frame%0d rx_valid pulses", idx), 64'(rxv_cnt), 64'(c_RX));
        if (c_RX != 0) begin
            chk($sformatf("frame%0d rx_left", idx), 64'(rxl_seen), 64'(v.fl));
            chk($sformatf("frame%0d rx_right", idx), 64'(rxr_seen), 64'(v.fr));
        end else begin
            chk($sformatf("frame%0d rx_left", idx), 64'(rx_left), 64'd0);
            chk($sformatf("frame%0d rx_right", idx), 64'(rx_right), 64'd0);
        end
    endtask

    // Checks the reset values of every output
    task automatic chk_reset_state(input string tag);
        chk({tag, " ctl"}, 64'({bclk, lrclk, sdata_out, tx_ready, rx_valid}), 64'b10000);
        chk({tag, " rx_left"}, 64'(rx_left), 64'd0);
        chk({tag, " rx_right"}, 64'(rx_right), 64'd0);
    endtask

    // Releases reset, then checks the first clock leaves bclk high
    task automatic release_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, " tx_ready after release"}, 64'(tx_ready), 64'd1);
        cyc();
        chk({tag, " bclk before first fall"}, 64'(bclk), 64'd1);
    endtask

    initial begin
        vec_t z;
        tv[0] = '{10, 14'h2AAA, 14'h1555, 1'b0, 14'h0, 14'h0,
                  64'h0000_0000_0000_0000, 64'hFFE0_0000_0000_0000, 14'h0000, 14'h0000};
        tv[1] = '{5, 14'h3FFF, 14'h0001, 1'b0, 14'h0, 14'h0,
                  64'hAAA8_0000_5554_0000, 64'hFC00_0000_0000_0000, 14'h2AAA, 14'h1555};
        tv[2] = '{-1, 14'h0, 14'h0, 1'b0, 14'h0, 14'h0,
                  64'hFFFC_0000_0004_0000, 64'hFFFF_FFFF_FFFF_FFFF, 14'h3FFF, 14'h0001};
        tv[3] = '{-1, 14'h0, 14'h0, 1'b0, 14'h0, 14'h0,
                  64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 14'h0000, 14'h0000};
        tv[4] = '{20, 14'h2001, 14'h1234, 1'b0, 14'h0, 14'h0,
                  64'h0000_0000_0000_0000, 64'hFFFF_F800_0000_0000, 14'h0000, 14'h0000};
        tv[5] = '{10, 14'h0F0F, 14'h30F0, 1'b1, 14'h2AAA, 14'h1555,
                  64'h8004_0000_48D0_0000, 64'hFFE0_0000_0000_0000, 14'h2001, 14'h1234};
        tv[6] = '{-1, 14'h0, 14'h0, 1'b0, 14'h0, 14'h0,
                  64'h3C3C_0000_C3C0_0000, 64'h8000_0000_0000_0000, 14'h0F0F, 14'h30F0};
        tv[7] = '{-1, 14'h0, 14'h0, 1'b0, 14'h0, 14'h0,
                  64'hAAA8_0000_5554_0000, 64'hFFFF_FFFF_FFFF_FFFF, 14'h2AAA, 14'h1555};

        // Power-on reset
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (3) cyc();
        chk_reset_state("por");
        release_reset("por");

        // Back-to-back frames, including the offer-in-wrap-cycle case (5..7)
        for (int i = 0; i < 8; i++) begin
            run_frame(tv[i], i);
        end

        // Reset at bit 40 with a pair held: nothing published, pair discarded
        for (int b = 0; b <= 40; b++) begin
            cyc();
            if (b == 5) begin
                tx_left  = 14'h3FFF;
                tx_right = 14'h3FFF;
                tx_valid = 1'b1;
            end
            if (b < 40) repeat (3) cyc();
        end
        tx_valid = 1'b0;
        reset    = 1'b1;
        rxv_cnt  = 0;
        cyc();
        chk_reset_state("mid-frame reset");
        repeat (30) cyc();
        chk("mid-frame reset rx_valid pulses", 64'(rxv_cnt), 64'd0);
        release_reset("mid-frame reset");
        z = '{-1, 14'h0, 14'h0, 1'b0, 14'h0, 14'h0,
              64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 14'h0, 14'h0};
        run_frame(z, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/audio_serial_master.md
AUDIO_SERIAL_MASTER -- requirements
Module: audio_serial_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, meaning sample width per channel.
REQ-002 SHALL have parameter BCLK_DIV, default 8, meaning CLOCK_50 cycles per BCLK half-period (legal 2..255).
REQ-003 SHALL have port CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports tx_left, tx_right  in  DATA_WIDTH; tx_valid  in  1; tx_ready  out  1, meaning the playback sample pair and its handshake.
REQ-006 SHALL have ports rx_left, rx_right  out  DATA_WIDTH; rx_valid  out  1, meaning the captured sample pair and its one-cycle strobe.
REQ-007 SHALL have ports bclk, lrclk, sdata_out  out  1; sdata_in  in  1, meaning the serial link in master role.
REQ-008 SHALL drive bclk, lrclk and sdata_out as plain outputs, never tri-stated.

Function
REQ-009 SHALL use a divider counter 0..BCLK_DIV-1 and toggle bclk on its terminal count; 64 BCLK periods form one frame.
REQ-010 SHALL advance a 6-bit bit counter on every bclk falling toggle, wrapping 63->0.
REQ-011 SHALL drive lrclk high (left) for bit counter 0..31 and low (right) for 32..63, updated on the same falling toggle.
REQ-012 SHALL use left-justified format: the channel MSB is on sdata_out from the falling toggle at bit index 0 (within the half-frame); one bit per falling toggle; indices DATA_WIDTH..31 drive 0.
REQ-013 SHALL provide a single-entry holding register; tx_ready = holding empty; a sample pair is accepted when tx_valid and tx_ready are both high on a CLOCK_50 edge.
REQ-014 SHALL load the left/right shift registers from the holding register on the 63->0 wrap and mark it empty in the same cycle.
REQ-015 SHALL, if the holding register is empty at wrap, transmit zeros for that frame (underflow).
REQ-016 SHALL, on acceptance and wrap in the same cycle, load the old holding contents (or zeros if empty) and store the newly accepted pair for the next frame.
REQ-017 SHALL sample sdata_in on bclk rising toggles at bit indices 0..DATA_WIDTH-1 of each half, MSB first.
REQ-018 SHALL update rx_left/rx_right together and pulse rx_valid for exactly one CLOCK_50 cycle after the right channel's last data bit is captured; the outputs hold until the next update.

Reset
REQ-019 SHALL on reset set bclk=1, lrclk=0, sdata_out=0, divider=0, bit counter=63, holding empty, tx_ready=0 during reset and 1 afterwards, rx_left=rx_right=0, rx_valid=0.
REQ-020 SHALL make the first bclk toggle after reset release a falling edge that starts frame bit 0 with lrclk=1.
REQ-021 SHALL, on reset mid-frame, discard the partial frame and any held sample without emitting rx_valid.

Configuration
REQ-022 SHALL compile the receive path (REQ-017, REQ-018) only when AUDIO_MASTER_RX_EN is defined; without it, rx_left/rx_right are tied to 0, rx_valid is tied to 0, sdata_in is ignored and no capture registers exist.

Structure
REQ-023 SHALL place the frame constants (64 bits per frame, 32 per channel) and the bit-counter width in the shared package audio_pkg.
REQ-024 SHALL use one sub-module, audio_bclk_gen (divider, bclk, and rising/falling toggle strobes); serialization and capture remain in the top module.

Verification (DATA_WIDTH=14, BCLK_DIV=2)
REQ-025 SHALL verify: release reset -> first bclk fall 2 cycles later, lrclk=1, and the bclk period is 4 CLOCK_50 cycles.
REQ-026 SHALL verify: accept L=14'h2AAA, R=14'h1555 before the wrap -> sdata_out bits 1010101010101000.. (left), then 01010101010101 00.. (right).
REQ-027 SHALL verify: no tx_valid for a whole frame -> sdata_out all 0 for 64 bits, and tx_ready stays 1.
REQ-028 SHALL verify: tx_valid asserted in the exact wrap cycle with the holding register full -> the old pair is sent, the new pair is sent next frame, and tx_ready drops for one frame.
REQ-029 SHALL verify (with AUDIO_MASTER_RX_EN): sdata_in looped to sdata_out -> rx_left=14'h2AAA, rx_right=14'h1555, and rx_valid is a one-cycle pulse once per frame.
REQ-030 SHALL verify: reset asserted at bit 40 -> outputs return to their REQ-019 values next cycle, with no rx_valid pulse.
